// File: rtl/clkset_pkg.sv
// rtl/clkset_pkg.sv - shared types, moduli and hour-index helper for the clock set sequencer
//
// Purpose : state encodings, field moduli and the 12h -> 0..23 hour index
//           mapping shared by clock_set_sequencer and clkset_phase_step.
// Contents: state_e (top FSM), sub_e (per-phase compare/advance/gap FSM),
//           MIN_MOD / HIDX_MOD / DAY_MOD, hour_index().
package clkset_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTER = 3'd1,
    MIN   = 3'd2,
    HRS   = 3'd3,
    DAY   = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SUB_CMP = 2'd0,
    SUB_ADV = 2'd1,
    SUB_GAP = 2'd2
  } sub_e;

  localparam int MIN_MOD  = 60;
  localparam int HIDX_MOD = 24;
  localparam int DAY_MOD  = 7;

  // hrs is the 0..11 counter form (0 = displayed 12). Out-of-range feedback
  // is folded back into 0..23 so the compare never sees an impossible index.
  function automatic logic [6:0] hour_index(input logic [6:0] hrs, input logic pm);
    logic [6:0] idx;
    idx = hrs + (pm ? 7'd12 : 7'd0);
    if (idx >= 7'(HIDX_MOD)) begin
      idx = idx - 7'(HIDX_MOD);
    end
    return idx;
  endfunction

endpackage

// File: rtl/clkset_phase_step.sv
// rtl/clkset_phase_step.sv - compare / advance / gap engine shared by the MIN, HRS and DAY phases
//
// Purpose : while active_i is high, compares the muxed field each compare
//           cycle; on mismatch requests one advance pulse followed by ADV_GAP
//           idle cycles, then compares again.
// Config  : CLKSET_TIMEOUT_EN adds a per-phase step counter; after MAX_STEPS
//           pulses without a match the next mismatching compare raises
//           timeout_o instead of another pulse.
// Ports   :
//   clk_i       in  clock
//   rst_i       in  synchronous reset, active-high
//   active_i    in  top FSM is in a phase state (MIN/HRS/DAY)
//   eq_i        in  current field equals target field
//   match_o     out compare cycle found a match (phase complete)
//   adv_next_o  out an advance pulse is issued in the next cycle
//   timeout_o   out step limit reached without a match
module clkset_phase_step
  import clkset_pkg::*;
#(
  parameter int ADV_GAP   = 0,
  parameter int MAX_STEPS = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic eq_i,
  output logic match_o,
  output logic adv_next_o,
  output logic timeout_o
);

  sub_e        sub_q, sub_d;
  logic [15:0] gap_q, gap_d;
  logic        at_limit;

`ifdef CLKSET_TIMEOUT_EN
  logic [15:0] step_q, step_d;

  assign at_limit = (step_q >= 16'(MAX_STEPS));

  // Cleared whenever the phase is left or completes so each phase gets its
  // own budget of MAX_STEPS pulses.
  always_comb begin
    step_d = step_q;
    if (!active_i || match_o) begin
      step_d = '0;
    end else if (adv_next_o) begin
      step_d = step_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end
`else
  logic [31:0] unused_max_steps;
  assign unused_max_steps = 32'(MAX_STEPS);
  assign at_limit         = 1'b0;
`endif

  always_comb begin
    sub_d      = sub_q;
    gap_d      = gap_q;
    match_o    = 1'b0;
    adv_next_o = 1'b0;
    timeout_o  = 1'b0;
    if (!active_i) begin
      sub_d = SUB_CMP;
      gap_d = '0;
    end else begin
      case (sub_q)
        SUB_CMP: begin
          if (eq_i) begin
            match_o = 1'b1;
          end else if (at_limit) begin
            timeout_o = 1'b1;
          end else begin
            adv_next_o = 1'b1;
            sub_d      = SUB_ADV;
          end
        end
        SUB_ADV: begin
          if (ADV_GAP == 0) begin
            sub_d = SUB_CMP;
          end else begin
            sub_d = SUB_GAP;
            gap_d = 16'(ADV_GAP);
          end
        end
        SUB_GAP: begin
          // gap_q counts ADV_GAP..1, one idle cycle per value.
          gap_d = gap_q - 16'd1;
          if (gap_q <= 16'd1) begin
            sub_d = SUB_CMP;
          end
        end
        default: sub_d = SUB_CMP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sub_q <= SUB_CMP;
      gap_q <= '0;
    end else begin
      sub_q <= sub_d;
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/clock_set_sequencer.sv
// rtl/clock_set_sequencer.sv - drives a clock's Timeset/Alarmset and advance buttons until its time or alarm matches a target
//
// Purpose : accepts a target (time or alarm), validates it, raises the
//           matching set line and steps minutes, then hours, then day
//           (time only) with single advance pulses until the fed-back value
//           matches, then pulses done_o.
// Config  : CLKSET_TIMEOUT_EN enables the per-phase MAX_STEPS timeout (err_o).
// Ports   :
//   clk_i        in  clock, same as the clock counters' Pulse
//   rst_i        in  synchronous reset, active-high
//   start_i      in  one-cycle request, honoured only when idle
//   tgt_alarm_i  in  0 = set time, 1 = set alarm (day phase skipped)
//   tgt_hrs_i    in  target hour 1..12
//   tgt_min_i    in  target minute 0..59
//   tgt_pm_i     in  target PM flag
//   tgt_day_i    in  target day 0..6
//   cur_hrs_i    in  fed-back hour counter 0..11 (0 = displayed 12)
//   cur_min_i    in  fed-back minute counter
//   cur_pm_i     in  fed-back PM flag
//   cur_day_i    in  fed-back day counter
//   timeset_o    out clock Timeset button
//   alarmset_o   out clock Alarmset button
//   minadv_o     out minute advance pulse
//   hrsadv_o     out hour advance pulse
//   dayadv_o     out day advance pulse
//   busy_o       out high whenever not idle
//   done_o       out one-cycle completion pulse
//   err_o        out one-cycle error pulse (invalid target or timeout)
module clock_set_sequencer
  import clkset_pkg::*;
#(
  parameter int ADV_GAP   = 0,
  parameter int MAX_STEPS = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       tgt_alarm_i,
  input  logic [3:0] tgt_hrs_i,
  input  logic [5:0] tgt_min_i,
  input  logic       tgt_pm_i,
  input  logic [2:0] tgt_day_i,
  input  logic [6:0] cur_hrs_i,
  input  logic [6:0] cur_min_i,
  input  logic       cur_pm_i,
  input  logic [2:0] cur_day_i,
  output logic       timeset_o,
  output logic       alarmset_o,
  output logic       minadv_o,
  output logic       hrsadv_o,
  output logic       dayadv_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e     state_q, state_d;
  logic       tgt_alarm_q, tgt_alarm_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [6:0] tgt_hidx_q, tgt_hidx_d;
  logic [2:0] tgt_day_q, tgt_day_d;

  logic timeset_q, timeset_d;
  logic alarmset_q, alarmset_d;
  logic minadv_q, minadv_d;
  logic hrsadv_q, hrsadv_d;
  logic dayadv_q, dayadv_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic tgt_valid;
  logic phase_active;
  logic field_eq;
  logic step_match;
  logic step_adv_next;
  logic step_timeout;
  logic set_on;

  assign tgt_valid = (tgt_hrs_i >= 4'd1) && (tgt_hrs_i <= 4'd12) &&
                     (int'(tgt_min_i) < MIN_MOD) && (int'(tgt_day_i) < DAY_MOD);

  assign phase_active = (state_q == MIN) || (state_q == HRS) || (state_q == DAY);

  // Field mux feeding the single shared step engine; cur_* is re-read on
  // every compare so extra carries from the clock are simply absorbed.
  always_comb begin
    field_eq = 1'b0;
    case (state_q)
      MIN:     field_eq = (cur_min_i == {1'b0, tgt_min_q});
      HRS:     field_eq = (hour_index(cur_hrs_i, cur_pm_i) == tgt_hidx_q);
      DAY:     field_eq = (cur_day_i == tgt_day_q);
      default: field_eq = 1'b0;
    endcase
  end

  clkset_phase_step #(
    .ADV_GAP   (ADV_GAP),
    .MAX_STEPS (MAX_STEPS)
  ) u_step (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .active_i   (phase_active),
    .eq_i       (field_eq),
    .match_o    (step_match),
    .adv_next_o (step_adv_next),
    .timeout_o  (step_timeout)
  );

  always_comb begin
    state_d     = state_q;
    tgt_alarm_d = tgt_alarm_q;
    tgt_min_d   = tgt_min_q;
    tgt_hidx_d  = tgt_hidx_q;
    tgt_day_d   = tgt_day_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (tgt_valid) begin
            state_d     = ENTER;
            tgt_alarm_d = tgt_alarm_i;
            tgt_min_d   = tgt_min_i;
            // Displayed 12 is counter value 0.
            tgt_hidx_d  = hour_index((tgt_hrs_i == 4'd12) ? 7'd0 : {3'b000, tgt_hrs_i},
                                     tgt_pm_i);
            tgt_day_d   = tgt_day_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ENTER: state_d = MIN;
      MIN: begin
        if (step_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (step_match) begin
          state_d = HRS;
        end
      end
      HRS: begin
        if (step_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (step_match) begin
          state_d = tgt_alarm_q ? DONE : DAY;
        end
      end
      DAY: begin
        if (step_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (step_match) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered and
  // aligned with the state they describe.
  always_comb begin
    set_on     = (state_d == ENTER) || (state_d == MIN) ||
                 (state_d == HRS)   || (state_d == DAY);
    timeset_d  = set_on && !tgt_alarm_d;
    alarmset_d = set_on && tgt_alarm_d;
    minadv_d   = (state_q == MIN) && step_adv_next;
    hrsadv_d   = (state_q == HRS) && step_adv_next;
    dayadv_d   = (state_q == DAY) && step_adv_next;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tgt_alarm_q <= 1'b0;
      tgt_min_q   <= '0;
      tgt_hidx_q  <= '0;
      tgt_day_q   <= '0;
      timeset_q   <= 1'b0;
      alarmset_q  <= 1'b0;
      minadv_q    <= 1'b0;
      hrsadv_q    <= 1'b0;
      dayadv_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_alarm_q <= tgt_alarm_d;
      tgt_min_q   <= tgt_min_d;
      tgt_hidx_q  <= tgt_hidx_d;
      tgt_day_q   <= tgt_day_d;
      timeset_q   <= timeset_d;
      alarmset_q  <= alarmset_d;
      minadv_q    <= minadv_d;
      hrsadv_q    <= hrsadv_d;
      dayadv_q    <= dayadv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign timeset_o  = timeset_q;
  assign alarmset_o = alarmset_q;
  assign minadv_o   = minadv_q;
  assign hrsadv_o   = hrsadv_q;
  assign dayadv_o   = dayadv_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_clock_set_sequencer.sv
// tb/tb_clock_set_sequencer.sv - self-checking bench for clock_set_sequencer with a clock model in the loop
module tb_clock_set_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       tgt_alarm = 1'b0;
  logic [3:0] tgt_hrs = 4'd1;
  logic [5:0] tgt_min = 6'd0;
  logic       tgt_pm = 1'b0;
  logic [2:0] tgt_day = 3'd0;
  logic       timeset, alarmset, minadv, hrsadv, dayadv, busy, done, err;

  // Clock model: time registers (m_*) and alarm registers (a_*).
  logic [6:0] m_min = '0, m_hrs = '0, a_min = '0, a_hrs = '0;
  logic       m_pm = 1'b0, a_pm = 1'b0;
  logic [2:0] m_day = '0;
  logic       ld_en = 1'b0, ld_alarm = 1'b0, ld_pm = 1'b0, freeze_min = 1'b0;
  logic [6:0] ld_min = '0, ld_hrs = '0;
  logic [2:0] ld_day = '0;

  int errors = 0;
  int checks = 0;
  int viol = 0;

  always #5 clk = ~clk;

  clock_set_sequencer #(.ADV_GAP(0), .MAX_STEPS(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .tgt_alarm_i (tgt_alarm),
    .tgt_hrs_i   (tgt_hrs),
    .tgt_min_i   (tgt_min),
    .tgt_pm_i    (tgt_pm),
    .tgt_day_i   (tgt_day),
    .cur_hrs_i   (tgt_alarm ? a_hrs : m_hrs),
    .cur_min_i   (tgt_alarm ? a_min : m_min),
    .cur_pm_i    (tgt_alarm ? a_pm : m_pm),
    .cur_day_i   (m_day),
    .timeset_o   (timeset),
    .alarmset_o  (alarmset),
    .minadv_o    (minadv),
    .hrsadv_o    (hrsadv),
    .dayadv_o    (dayadv),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_alarm) begin
        a_min <= ld_min; a_hrs <= ld_hrs; a_pm <= ld_pm;
      end else begin
        m_min <= ld_min; m_hrs <= ld_hrs; m_pm <= ld_pm; m_day <= ld_day;
      end
    end else begin
      if (timeset && minadv && !freeze_min) begin
        if (m_min == 7'd59) begin
          m_min <= 7'd0;
          // Minute carry into the hour; 11 PM -> 12 AM also carries the day.
          if (m_hrs == 7'd11) begin
            m_hrs <= 7'd0;
            m_pm  <= ~m_pm;
            if (m_pm) m_day <= (m_day == 3'd6) ? 3'd0 : m_day + 3'd1;
          end else begin
            m_hrs <= m_hrs + 7'd1;
          end
        end else begin
          m_min <= m_min + 7'd1;
        end
      end
      if (timeset && hrsadv) begin
        if (m_hrs == 7'd11) begin m_hrs <= 7'd0; m_pm <= ~m_pm; end
        else m_hrs <= m_hrs + 7'd1;
      end
      if (timeset && dayadv) m_day <= (m_day == 3'd6) ? 3'd0 : m_day + 3'd1;
      if (alarmset && minadv) a_min <= (a_min == 7'd59) ? 7'd0 : a_min + 7'd1;
      if (alarmset && hrsadv) begin
        if (a_hrs == 7'd11) begin a_hrs <= 7'd0; a_pm <= ~a_pm; end
        else a_hrs <= a_hrs + 7'd1;
      end
    end
  end

  // Structural rule: at most one advance, advances only under a set line,
  // never both set lines together.
  always @(negedge clk) begin
    if (!rst) begin
      if ((32'(minadv) + 32'(hrsadv) + 32'(dayadv)) > 1 ||
          ((minadv | hrsadv | dayadv) && !(timeset | alarmset)) ||
          (timeset && alarmset))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_model(input logic alarm, input int mn, input int hr, input logic pm,
                            input int dy);
    @(negedge clk);
    ld_alarm = alarm; ld_min = 7'(mn); ld_hrs = 7'(hr); ld_pm = pm; ld_day = 3'(dy);
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_target(input logic alarm, input int hr, input int mn, input logic pm,
                            input int dy);
    tgt_alarm = alarm; tgt_hrs = 4'(hr); tgt_min = 6'(mn); tgt_pm = pm; tgt_day = 3'(dy);
  endtask

  typedef struct {
    logic alarm;
    int   i_min, i_hrs; logic i_pm; int i_day;
    int   t_hrs, t_min; logic t_pm; int t_day;
    int   e_min, e_hrs, e_day;
    logic mid;
  } op_t;

  task automatic run_op(input int idx, input op_t op, input int exp_nmin);
    int nmin, nhrs, nday, got_done, got_err, saw_err;
    nmin = 0; nhrs = 0; nday = 0; got_done = 0; got_err = 0; saw_err = 0;
    @(negedge clk);
    set_target(op.alarm, op.t_hrs, op.t_min, op.t_pm, op.t_day);
    start = 1'b1;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (op.mid && c == 5) begin start = 1'b1; tgt_hrs = 4'd13; end
      if (op.mid && c == 6) tgt_hrs = 4'(op.t_hrs);
      if (minadv) nmin++;
      if (hrsadv) nhrs++;
      if (dayadv) nday++;
      if (err) saw_err = 1;
      if (done) begin got_done = 1; break; end
    end
    @(negedge clk);
    chk($sformatf("op%0d done", idx), got_done, 1);
    chk($sformatf("op%0d err", idx), saw_err, 0);
    chk($sformatf("op%0d minadv", idx), nmin, exp_nmin);
    chk($sformatf("op%0d hrsadv", idx), nhrs, op.e_hrs);
    chk($sformatf("op%0d dayadv", idx), nday, op.e_day);
    if (op.alarm) begin
      chk($sformatf("op%0d a_min", idx), int'(a_min), op.t_min);
      chk($sformatf("op%0d a_hrs", idx), int'(a_hrs), (op.t_hrs == 12) ? 0 : op.t_hrs);
      chk($sformatf("op%0d a_pm", idx), int'(a_pm), int'(op.t_pm));
    end else begin
      chk($sformatf("op%0d m_min", idx), int'(m_min), op.t_min);
      chk($sformatf("op%0d m_hrs", idx), int'(m_hrs), (op.t_hrs == 12) ? 0 : op.t_hrs);
      chk($sformatf("op%0d m_pm", idx), int'(m_pm), int'(op.t_pm));
      chk($sformatf("op%0d m_day", idx), int'(m_day), op.t_day);
    end
    chk($sformatf("op%0d busy after", idx), int'(busy), 0);
  endtask

  op_t ops[5];
  logic [5:0] cyc_exp[11];
  int bad_hrs[4], bad_min[4], bad_day[4];

  initial begin
    // alarm, i_min,i_hrs,i_pm,i_day, t_hrs,t_min,t_pm,t_day, e_min,e_hrs,e_day, mid
    ops[0] = '{1'b0, 58, 11, 1'b1, 6, 12,  1, 1'b0, 0,  3,  0, 0, 1'b0};
    ops[1] = '{1'b1,  0,  7, 1'b0, 0,  6, 30, 1'b0, 0, 30, 23, 0, 1'b1};
    ops[2] = '{1'b0, 10,  3, 1'b1, 1,  3, 10, 1'b1, 1,  0,  0, 0, 1'b0};
    ops[3] = '{1'b0, 20,  1, 1'b0, 5,  2,  5, 1'b0, 2, 45,  0, 4, 1'b0};
    ops[4] = '{1'b0,  0,  0, 1'b1, 0, 12,  0, 1'b0, 3,  0, 12, 3, 1'b0};
    bad_hrs = '{13, 0, 5, 5};
    bad_min = '{0, 0, 60, 0};
    bad_day = '{0, 0, 0, 7};
    // {timeset, minadv, hrsadv, dayadv, done, busy} for cycles 1..10 of the 10:15 -> 10:17 run
    for (int c = 1; c <= 10; c++)
      cyc_exp[c] = {(c >= 1 && c <= 8), (c == 3 || c == 5), 1'b0, 1'b0, (c == 9),
                    (c >= 1 && c <= 9)};

    repeat (3) @(negedge clk);
    chk("reset outputs", int'({timeset, alarmset, minadv, hrsadv, dayadv, busy, done, err}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle outputs", int'({timeset, alarmset, minadv, hrsadv, dayadv, busy, done, err}), 0);

    // Cycle-exact run: 10:15 AM day 2 -> 10:17 AM day 2.
    load_model(1'b0, 15, 10, 1'b0, 2);
    @(negedge clk);
    set_target(1'b0, 10, 17, 1'b0, 2);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("cyc%0d {ts,ma,ha,da,dn,bz}", c),
          int'({timeset, minadv, hrsadv, dayadv, done, busy}), int'(cyc_exp[c]));
    end

    // Invalid targets: one err pulse, nothing else moves.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_target(1'b0, bad_hrs[i], bad_min[i], 1'b0, bad_day[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("bad%0d err", i), int'(err), 1);
      chk($sformatf("bad%0d busy/set/adv", i),
          int'({busy, timeset, alarmset, minadv, hrsadv, dayadv, done}), 0);
      @(negedge clk);
      chk($sformatf("bad%0d err cleared", i), int'({err, busy}), 0);
    end

    // Table of full operations with the clock model closing the loop.
    for (int i = 0; i < 5; i++) begin
      load_model(ops[i].alarm, ops[i].i_min, ops[i].i_hrs, ops[i].i_pm, ops[i].i_day);
      run_op(i, ops[i], ops[i].e_min);
    end

    // Reset in cycle 4 of the minute phase, then a fresh run.
    load_model(1'b0, 0, 1, 1'b0, 4);
    @(negedge clk);
    set_target(1'b0, 1, 30, 1'b0, 4);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst outputs", int'({timeset, alarmset, minadv, hrsadv, dayadv, busy, done, err}), 0);
    rst = 1'b0;
    chk("rst model min", int'(m_min), 1);
    // One minute was already stepped before reset; 29 more remain.
    run_op(5, '{1'b0, 1, 1, 1'b0, 4, 1, 30, 1'b0, 4, 29, 0, 0, 1'b0}, 29);

`ifdef CLKSET_TIMEOUT_EN
    begin
      int nmin, got_err, got_done;
      nmin = 0; got_err = 0; got_done = 0;
      load_model(1'b0, 5, 0, 1'b0, 0);
      freeze_min = 1'b1;
      @(negedge clk);
      set_target(1'b0, 12, 20, 1'b0, 0);
      start = 1'b1;
      for (int c = 1; c < 200; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (minadv) nmin++;
        if (done) got_done = 1;
        if (err) begin
          got_err = 1;
          chk("timeout set line", int'({timeset, busy}), 0);
          break;
        end
      end
      freeze_min = 1'b0;
      chk("timeout err", got_err, 1);
      chk("timeout minadv", nmin, 8);
      chk("timeout done", got_done, 0);
      @(negedge clk);
      chk("timeout err cleared", int'(err), 0);
    end
`endif

    chk("structural violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_sequencer.md
Name: clock_set_sequencer

Overview:
- Initiator side of the clock's manual-set interface: drives Timeset/Alarmset with Minadv/Hrsadv/Dayadv pulses until the clock's fed-back time or alarm matches a requested target.
- Replaces the human at the push-buttons, for a host/UART command path or a self-test bench.
- Sits beside the clock top level. Shares its Pulse-rate clock domain. Outputs wire to the clock's button inputs.

Parameters:
- ADV_GAP, 0, idle cycles inserted after each advance pulse before the next compare.
- MAX_STEPS, 64, per-phase advance-pulse limit (used only when the timeout feature is compiled in).

Ports:
- clk  in  1  clock (same as clock counters' Pulse).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- tgt_alarm  in  1  0 = set time (Timeset path), 1 = set alarm (Alarmset path, day skipped).
- tgt_hrs  in  4  target hour, 1..12.
- tgt_min  in  6  target minute, 0..59.
- tgt_pm  in  1  target PM flag.
- tgt_day  in  3  target day, 0..6 (ignored when tgt_alarm = 1).
- cur_hrs  in  7  fed-back hour counter, 0..11 (0 = displayed 12).
- cur_min  in  7  fed-back minute counter.
- cur_pm  in  1  fed-back PM flag.
- cur_day  in  3  fed-back day counter.
- timeset  out  1  drives clock Timeset.
- alarmset  out  1  drives clock Alarmset.
- minadv, hrsadv, dayadv  out  1  advance pulses.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; target registers 0.
- All outputs are registered. The caller muxes cur_* (time vs alarm registers) to match tgt_alarm.
- IDLE:
  - start=1 with tgt_hrs in 1..12, tgt_min<=59 and tgt_day<=6 → latch the targets and go to ENTER.
  - start=1 with any invalid field → err=1 for 1 cycle, stay in IDLE, no set line raised.
- Target encoding: hour index = pm*12 + (tgt_hrs==12 ? 0 : tgt_hrs). Current hour index = cur_pm*12 + cur_hrs.
- ENTER (1 cycle): raise timeset (tgt_alarm=0) or alarmset (tgt_alarm=1). The raised line stays high through the last phase.
- Phase order is MIN → HRS → DAY. Minutes go first because a minute wrap at 59 carries into hours. Hours go before day because an hour wrap can advance the day.
- Each phase loops on a compare cycle:
  - Field equal → move to the next phase.
  - Field not equal → 1 cycle of the phase's adv pulse, then ADV_GAP idle cycles, then back to compare.
  - A step therefore costs 2+ADV_GAP cycles; the final matching compare costs 1 cycle.
- Advancing is forward-only. The sequencer wraps through the modulus: 60 for minutes, 24 for hour index, 7 for day.
- DAY is skipped (0 cycles) when tgt_alarm=1.
- DONE (1 cycle): set line returns to 0, done=1, busy=1. Next state is IDLE.
- At most one adv output is high in any cycle, and never while the set line is low.
- start during busy is ignored.
- Feedback changing mid-phase (e.g. an extra carry increment) is tolerated: each compare re-reads cur_*.
- rst mid-operation: all outputs 0 in the next cycle and state returns to IDLE. No done/err pulse.

Optional Feature:
- Macro CLKSET_TIMEOUT_EN.
- Defined: a per-phase step counter runs. If MAX_STEPS advance pulses are issued without a match, the sequencer drops the set line, pulses err=1 for 1 cycle (done stays 0) and returns to IDLE.
- Not defined: no counter and no timeout. err is raised only for invalid targets.

Decomposition:
- Shared package clkset_pkg:
  - state enum: IDLE, ENTER, MIN, HRS, DAY, DONE.
  - constants MIN_MOD=60, HIDX_MOD=24, DAY_MOD=7.
  - function hour_index(hrs, pm).
- One natural sub-module, clkset_phase_step: compare / adv / gap sub-counter and step counter. Instantiated once and shared across phases via a field mux.

Test Plan:
- Time 10:15 AM day 2, target 10:17 AM day 2, ADV_GAP=0, start in cycle 0 → timeset high cycles 1–8; minadv high in cycles 3 and 5; done=1 in cycle 9; hrsadv/dayadv never high.
- Time 11:58 PM day 6, target 12:01 AM day 0, with a clock model in the loop → 3 minadv pulses (the 59→00 step carries the hour model to 12 AM and the day to 0); hrsadv count 0; done pulses with the model showing 12:01 AM day 0.
- Alarm 7:00 AM, tgt_alarm=1, target 6:30 AM → alarmset high throughout, timeset 0; 30 minadv then 23 hrsadv; no dayadv; done.
- start with tgt_hrs=13 → err=1 for 1 cycle, busy stays 0, all set/adv lines 0.
- With CLKSET_TIMEOUT_EN, MAX_STEPS=8, cur_min stuck at 5, target 20 → 8 minadv pulses, then err=1 and timeset=0.
- rst asserted in cycle 4 of a minute phase → the next cycle has all outputs 0 and busy 0; a fresh start runs normally.
